// File: rtl/sram_page_walker.sv
// Read-side page-chain walker: follows jump-table links from a head page, presents
// each page (with its ECC byte) downstream, and emits a release pulse per consumed page.
module sram_page_walker #(
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_PAGES  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [3:0]            start_port,
    output logic                  busy,
    output logic                  jt_rd_en,
    output logic [ADDR_WIDTH-1:0] jt_rd_addr,
    input  logic [15:0]           jt_dout,
    output logic                  ecc_rd_en,
    output logic [ADDR_WIDTH-1:0] ecc_rd_addr,
    input  logic [7:0]            ecc_dout,
    output logic                  page_valid,
    input  logic                  page_ready,
    output logic [ADDR_WIDTH-1:0] page_addr,
    output logic [7:0]            page_ecc,
    output logic                  page_last,
    output logic                  rd_op,
    output logic [3:0]            rd_port,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  done,
    output logic                  error,
    output logic [10:0]           pages_walked
);

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, PRESENT, RELEASE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur;
    logic [ADDR_WIDTH-1:0] nxt;
    logic [3:0]            port;
    logic [10:0]           cnt;
    logic [10:0]           cnt_inc;
    logic                  rsvd_unused;

    assign cnt_inc     = cnt + 11'd1;
    assign rsvd_unused = ^jt_dout[14:ADDR_WIDTH];

    // Jump table and ECC memory are always read together at the same page.
    assign ecc_rd_en   = jt_rd_en;
    assign ecc_rd_addr = jt_rd_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cur          <= '0;
            nxt          <= '0;
            port         <= '0;
            cnt          <= '0;
            busy         <= 1'b0;
            jt_rd_en     <= 1'b0;
            jt_rd_addr   <= '0;
            page_valid   <= 1'b0;
            page_addr    <= '0;
            page_ecc     <= '0;
            page_last    <= 1'b0;
            rd_op        <= 1'b0;
            rd_port      <= '0;
            rd_addr      <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            pages_walked <= '0;
        end else begin
            rd_op    <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            jt_rd_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur          <= start_addr;
                        port         <= start_port;
                        cnt          <= '0;
                        pages_walked <= '0;
                        busy         <= 1'b1;
                        jt_rd_en     <= 1'b1;
                        jt_rd_addr   <= start_addr;
                        state        <= FETCH;
                    end
                end
                FETCH: state <= CAPTURE;
                CAPTURE: begin
                    nxt        <= jt_dout[ADDR_WIDTH-1:0];
                    page_last  <= jt_dout[15];
                    page_ecc   <= ecc_dout;
                    page_addr  <= cur;
                    page_valid <= 1'b1;
                    state      <= PRESENT;
                end
                PRESENT: begin
                    // Release outcome is decided at the handshake so the RELEASE cycle
                    // carries rd_op, done/error and the next page's fetch together.
                    if (page_ready) begin
                        page_valid <= 1'b0;
                        cnt        <= cnt_inc;
                        rd_op      <= 1'b1;
                        rd_addr    <= page_addr;
                        rd_port    <= port;
                        state      <= RELEASE;
                        if (page_last) begin
                            done         <= 1'b1;
                            pages_walked <= cnt_inc;
                        end else if (cnt_inc == 11'(MAX_PAGES)) begin
                            done         <= 1'b1;
                            error        <= 1'b1;
                            pages_walked <= cnt_inc;
                        end else begin
                            cur        <= nxt;
                            jt_rd_en   <= 1'b1;
                            jt_rd_addr <= nxt;
                        end
                    end
                end
                RELEASE: begin
                    if (done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_page_walker.sv
// Bench for sram_page_walker: memory models, a cycle-level walk driver/monitor,
// and a chain-following reference model used against randomized chains.
module tb_sram_page_walker;

    localparam int AW   = 11;
    localparam int MAXP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [3:0]    start_port = '0;
    logic          busy, jt_rd_en, ecc_rd_en, page_valid, page_last, rd_op, done, error;
    logic [AW-1:0] jt_rd_addr, ecc_rd_addr, page_addr, rd_addr;
    logic [15:0]   jt_dout = '0;
    logic [7:0]    ecc_dout = '0;
    logic          page_ready = 1'b0;
    logic [7:0]    page_ecc;
    logic [3:0]    rd_port;
    logic [10:0]   pages_walked;
    logic [74:0]   all_out;

    logic [15:0] jt_mem  [0:2047];
    logic [7:0]  ecc_mem [0:2047];

    int checks = 0;
    int passes = 0;

    sram_page_walker #(.ADDR_WIDTH(AW), .MAX_PAGES(MAXP)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .start_port(start_port),
        .busy(busy), .jt_rd_en(jt_rd_en), .jt_rd_addr(jt_rd_addr), .jt_dout(jt_dout),
        .ecc_rd_en(ecc_rd_en), .ecc_rd_addr(ecc_rd_addr), .ecc_dout(ecc_dout),
        .page_valid(page_valid), .page_ready(page_ready), .page_addr(page_addr),
        .page_ecc(page_ecc), .page_last(page_last), .rd_op(rd_op), .rd_port(rd_port),
        .rd_addr(rd_addr), .done(done), .error(error), .pages_walked(pages_walked)
    );

    assign all_out = {busy, jt_rd_en, jt_rd_addr, ecc_rd_en, ecc_rd_addr, page_valid, page_addr,
                      page_ecc, page_last, rd_op, rd_port, rd_addr, done, error, pages_walked};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (jt_rd_en)  jt_dout  <= jt_mem[jt_rd_addr];
        if (ecc_rd_en) ecc_dout <= ecc_mem[ecc_rd_addr];
    end

    // Observations from one walk (cycle numbers are relative to the start cycle T).
    logic [10:0] o_addr[$];
    logic [7:0]  o_ecc[$];
    logic        o_last[$];
    int          o_cyc[$];
    logic [10:0] r_addr[$];
    logic [3:0]  r_port[$];
    int          r_cyc[$];
    int          done_cyc, done_cnt, err_cnt, viol, pw_done, pw_after;
    logic        busy_after;
    bit          timed_out;

    // Expected page sequence derived by following the stored chain.
    logic [10:0] e_addr[$];
    logic [7:0]  e_ecc[$];
    logic        e_last[$];
    bit          e_err;

    task automatic link(input logic [10:0] a, input logic [10:0] nx, input logic last, input logic [7:0] ecc);
        jt_mem[a]  = {last, 4'b0, nx};
        ecc_mem[a] = ecc;
    endtask

    task automatic model(input logic [10:0] head);
        logic [10:0] a;
        a = head;
        e_addr.delete(); e_ecc.delete(); e_last.delete(); e_err = 0;
        forever begin
            e_addr.push_back(a); e_ecc.push_back(ecc_mem[a]); e_last.push_back(jt_mem[a][15]);
            if (jt_mem[a][15]) break;
            if (e_addr.size() == MAXP) begin e_err = 1; break; end
            a = jt_mem[a][10:0];
        end
    endtask

    // Drives one walk and records what the DUT did; protocol invariants are tallied in viol.
    task automatic walk(input logic [10:0] head, input logic [3:0] port, input int stall_pg,
                        input int stall_len, input bit rnd_ready, input int inj_cyc);
        int          stalled = 0;
        bit          pv = 0, phs = 0;
        logic [10:0] pa = '0;
        logic [7:0]  pe = '0;
        logic        pl = 1'b0;
        o_addr.delete(); o_ecc.delete(); o_last.delete(); o_cyc.delete();
        r_addr.delete(); r_port.delete(); r_cyc.delete();
        done_cyc = -1; done_cnt = 0; err_cnt = 0; viol = 0; pw_done = -1; pw_after = -1;
        busy_after = 1'bx; timed_out = 1;
        @(negedge clk); start = 1; start_addr = head; start_port = port; page_ready = 0;
        @(negedge clk); start = 0;
        for (int n = 1; n <= 400; n++) begin
            if (done_cyc >= 0) begin
                busy_after = busy; pw_after = int'(pages_walked); timed_out = 0; break;
            end
            if (phs != rd_op) viol++;
            if (pv && !phs && (!page_valid || page_addr !== pa || page_ecc !== pe || page_last !== pl)) viol++;
            if (page_valid && (!pv || phs)) begin
                o_addr.push_back(page_addr); o_ecc.push_back(page_ecc); o_last.push_back(page_last);
                o_cyc.push_back(n); pa = page_addr; pe = page_ecc; pl = page_last;
            end
            if (rd_op) begin r_addr.push_back(rd_addr); r_port.push_back(rd_port); r_cyc.push_back(n); end
            if (error) begin err_cnt++; if (!done) viol++; end
            if (!busy) viol++;
            if (done) begin done_cnt++; done_cyc = n; pw_done = int'(pages_walked); end
            if (n == inj_cyc) begin start = 1; start_addr = 11'd99; start_port = 4'hF; end
            else start = 0;
            if (page_valid && o_addr.size() == stall_pg && stalled < stall_len) begin
                page_ready = 0; stalled++;
            end else begin
                page_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            pv = page_valid; phs = page_valid && page_ready;
            @(negedge clk);
        end
        start = 0; page_ready = 0;
    endtask

    task automatic test_reset();
        checks++; if (all_out !== '0) $display("FAIL reset_outputs got %h want 0", all_out); else passes++;
        rst = 0;
        @(negedge clk);
        checks++; if (all_out !== '0) $display("FAIL idle_outputs got %h want 0", all_out); else passes++;
    endtask

    task automatic test_single_page();
        link(11'd5, 11'd0, 1'b1, 8'hA5);
        walk(11'd5, 4'd3, 0, 0, 0, 0);
        checks++; if (timed_out) $display("FAIL single_timeout got 1 want 0"); else passes++;
        checks++; if (o_addr.size() != 1 || o_cyc[0] != 3) $display("FAIL single_valid_cyc got n=%0d cyc=%0d want 1/3", o_addr.size(), o_cyc[0]); else passes++;
        checks++; if ({o_addr[0], o_ecc[0], o_last[0]} !== {11'd5, 8'hA5, 1'b1}) $display("FAIL single_fields got %0d/%h/%b want 5/a5/1", o_addr[0], o_ecc[0], o_last[0]); else passes++;
        checks++; if (r_cyc.size() != 1 || r_cyc[0] != 4 || r_addr[0] !== 11'd5 || r_port[0] !== 4'd3) $display("FAIL single_release got n=%0d cyc=%0d addr=%0d port=%0d want 1/4/5/3", r_cyc.size(), r_cyc[0], r_addr[0], r_port[0]); else passes++;
        checks++; if (done_cyc != 4 || pw_done != 1 || err_cnt != 0) $display("FAIL single_done got cyc=%0d pw=%0d err=%0d want 4/1/0", done_cyc, pw_done, err_cnt); else passes++;
        checks++; if (busy_after !== 1'b0 || pw_after != 1) $display("FAIL single_after got busy=%b pw=%0d want 0/1", busy_after, pw_after); else passes++;
    endtask

    task automatic build_three();
        link(11'd10, 11'd200, 1'b0, 8'h11);
        link(11'd200, 11'd2047, 1'b0, 8'h22);
        link(11'd2047, 11'd0, 1'b1, 8'h33);
    endtask

    task automatic test_three_page();
        build_three();
        walk(11'd10, 4'd7, 0, 0, 0, 0);
        checks++; if (o_addr.size() != 3 || o_cyc[0] != 3 || o_cyc[1] != 6 || o_cyc[2] != 9) $display("FAIL three_valid_cycles got n=%0d %0d,%0d,%0d want 3,6,9", o_addr.size(), o_cyc[0], o_cyc[1], o_cyc[2]); else passes++;
        checks++; if ({o_addr[0], o_addr[1], o_addr[2]} !== {11'd10, 11'd200, 11'd2047}) $display("FAIL three_addrs got %0d,%0d,%0d want 10,200,2047", o_addr[0], o_addr[1], o_addr[2]); else passes++;
        checks++; if ({o_ecc[0], o_ecc[1], o_ecc[2], o_last[0], o_last[1], o_last[2]} !== {8'h11, 8'h22, 8'h33, 3'b001}) $display("FAIL three_ecc_last got %h,%h,%h last %b%b%b want 11,22,33 001", o_ecc[0], o_ecc[1], o_ecc[2], o_last[0], o_last[1], o_last[2]); else passes++;
        checks++; if (r_cyc.size() != 3 || {r_addr[0], r_addr[1], r_addr[2]} !== {11'd10, 11'd200, 11'd2047}) $display("FAIL three_releases got n=%0d want 3 in chain order", r_cyc.size()); else passes++;
        checks++; if (done_cyc != 10 || pw_done != 3 || viol != 0) $display("FAIL three_done got cyc=%0d pw=%0d viol=%0d want 10/3/0", done_cyc, pw_done, viol); else passes++;
    endtask

    task automatic test_backpressure();
        build_three();
        walk(11'd10, 4'd2, 2, 7, 0, 0);
        checks++; if (viol != 0) $display("FAIL bp_invariants got %0d violations want 0", viol); else passes++;
        checks++; if (o_cyc.size() != 3 || r_cyc.size() != 3 || r_cyc[1] != o_cyc[1] + 8) $display("FAIL bp_release_cycle got %0d want %0d", r_cyc[1], o_cyc[1] + 8); else passes++;
        checks++; if ({r_addr[0], r_addr[1], r_addr[2]} !== {11'd10, 11'd200, 11'd2047} || pw_done != 3) $display("FAIL bp_order got %0d,%0d,%0d pw=%0d want 10,200,2047 pw=3", r_addr[0], r_addr[1], r_addr[2], pw_done); else passes++;
    endtask

    task automatic test_guard();
        for (int i = 0; i < 6; i++) link(11'(300 + i), 11'(301 + i), 1'b0, 8'(i));
        walk(11'd300, 4'd9, 0, 0, 0, 0);
        checks++; if (r_cyc.size() != MAXP) $display("FAIL guard_release_count got %0d want %0d", r_cyc.size(), MAXP); else passes++;
        checks++; if (err_cnt != 1 || done_cnt != 1 || viol != 0) $display("FAIL guard_done_error got err=%0d done=%0d viol=%0d want 1/1/0", err_cnt, done_cnt, viol); else passes++;
        checks++; if (pw_done != MAXP || busy_after !== 1'b0) $display("FAIL guard_pw_busy got pw=%0d busy=%b want %0d/0", pw_done, busy_after, MAXP); else passes++;
    endtask

    task automatic test_reset_mid_walk();
        int seen = 0;
        link(11'd400, 11'd401, 1'b0, 8'h40);
        link(11'd401, 11'd402, 1'b0, 8'h41);
        link(11'd402, 11'd0, 1'b1, 8'h42);
        @(negedge clk); start = 1; start_addr = 11'd400; start_port = 4'd5; page_ready = 1;
        @(negedge clk); start = 0;
        repeat (4) @(negedge clk);
        page_ready = 0;
        @(negedge clk);
        checks++; if (!page_valid || page_addr !== 11'd401) $display("FAIL rstmid_page2 got v=%b addr=%0d want 1/401", page_valid, page_addr); else passes++;
        rst = 1;
        @(negedge clk);
        checks++; if (all_out !== '0) $display("FAIL rstmid_outputs got %h want 0", all_out); else passes++;
        rst = 0;
        repeat (10) begin @(negedge clk); if (rd_op || done || busy) seen++; end
        checks++; if (seen != 0) $display("FAIL rstmid_quiet got %0d active cycles want 0", seen); else passes++;
        walk(11'd400, 4'd5, 0, 0, 0, 0);
        checks++; if (r_cyc.size() != 3 || {r_addr[0], r_addr[1], r_addr[2]} !== {11'd400, 11'd401, 11'd402} || done_cyc != 10) $display("FAIL rstmid_restart got n=%0d done=%0d want 3/10", r_cyc.size(), done_cyc); else passes++;
    endtask

    task automatic test_start_while_busy();
        link(11'd99, 11'd0, 1'b1, 8'hEE);
        build_three();
        walk(11'd10, 4'd7, 0, 0, 0, 5);
        checks++; if (o_addr.size() != 3 || {o_addr[0], o_addr[1], o_addr[2]} !== {11'd10, 11'd200, 11'd2047}) $display("FAIL busy_start_pages got n=%0d want 10,200,2047", o_addr.size()); else passes++;
        checks++; if (done_cyc != 10 || pw_done != 3 || r_port[2] !== 4'd7 || viol != 0) $display("FAIL busy_start_done got cyc=%0d pw=%0d port=%0d viol=%0d want 10/3/7/0", done_cyc, pw_done, r_port[2], viol); else passes++;
        checks++; if (busy_after !== 1'b0) $display("FAIL busy_start_idle got %b want 0", busy_after); else passes++;
    endtask

    task automatic test_random();
        for (int w = 0; w < 20; w++) begin
            logic [10:0] a[6];
            int          len = $urandom_range(1, 6);
            logic [3:0]  p = 4'($urandom);
            for (int i = 0; i < 6; i++) a[i] = 11'($urandom_range(0, 2047));
            for (int i = 0; i < len; i++)
                link(a[i], (i == len - 1) ? 11'($urandom) : a[i+1], i == len - 1, 8'($urandom));
            model(a[0]);
            walk(a[0], p, 0, 0, 1, 0);
            checks++; if (timed_out || viol != 0) $display("FAIL rand%0d_protocol got timeout=%0b viol=%0d want 0/0", w, timed_out, viol); else passes++;
            checks++; if (o_addr.size() != e_addr.size() || r_addr.size() != e_addr.size()) $display("FAIL rand%0d_count got pages=%0d rel=%0d want %0d", w, o_addr.size(), r_addr.size(), e_addr.size()); else passes++;
            for (int i = 0; i < e_addr.size(); i++) begin
                checks++; if ({o_addr[i], o_ecc[i], o_last[i], r_addr[i], r_port[i]} !== {e_addr[i], e_ecc[i], e_last[i], e_addr[i], p}) $display("FAIL rand%0d_page%0d got %0d/%h/%b rel %0d/%0d want %0d/%h/%b rel %0d/%0d", w, i, o_addr[i], o_ecc[i], o_last[i], r_addr[i], r_port[i], e_addr[i], e_ecc[i], e_last[i], e_addr[i], p); else passes++;
            end
            checks++; if (err_cnt != int'(e_err) || pw_done != e_addr.size() || pw_after != pw_done) $display("FAIL rand%0d_end got err=%0d pw=%0d held=%0d want %0d/%0d", w, err_cnt, pw_done, pw_after, e_err, e_addr.size()); else passes++;
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin jt_mem[i] = '0; ecc_mem[i] = '0; end
        repeat (3) @(negedge clk);
        test_reset();
        test_single_page();
        test_three_page();
        test_backpressure();
        test_guard();
        test_reset_mid_walk();
        test_start_while_busy();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sram_page_walker.md
# sram_page_walker

Read-side traversal engine for the shared packet SRAM. Given a packet's head page and owning port, it walks the page chain stored in the jump table, fetches each page's ECC byte and presents the page to the downstream read datapath under a valid/ready handshake. After each page is consumed, it issues a one-cycle release (`rd_op`) so the state block frees the page into the null-page list. It mirrors the write-side chain builder, consuming what that block links.

## Interface
- `ADDR_WIDTH`, 11, page address width (2048 pages)
- `MAX_PAGES`, 64, chain-length guard; walk aborts with error if no last flag by this many pages
- `clk` input 1 — single clock, all logic rising-edge
- `rst` input 1 — synchronous, active-high reset
- `start` input 1 — request a walk; accepted only when `busy`=0
- `start_addr` input 11 — head page of the packet
- `start_port` input 4 — owning output port
- `busy` output 1 — walk in progress
- `jt_rd_en` output 1, `jt_rd_addr` output 11, `jt_dout` input 16 — jump-table read; 1-cycle registered latency; entry = {last[15], rsvd[14:11], next[10:0]}
- `ecc_rd_en` output 1, `ecc_rd_addr` output 11, `ecc_dout` input 8 — ECC read; same latency as the jump table
- `page_valid` output 1, `page_ready` input 1 — downstream handshake
- `page_addr` output 11, `page_ecc` output 8, `page_last` output 1 — current page info, stable while `page_valid`
- `rd_op` output 1, `rd_port` output 4, `rd_addr` output 11 — page release pulse to the state block
- `done` output 1 — 1-cycle pulse at the end of a walk
- `error` output 1 — 1-cycle pulse coincident with `done` on guard abort
- `pages_walked` output 11 — pages released in the last walk; held until the next `start`

## Operation
- FSM states: IDLE, FETCH, CAPTURE, PRESENT, RELEASE.
- IDLE: on `start`, latch `cur`=`start_addr` and `port`=`start_port`. Clear the page counter and `pages_walked`. Go to FETCH.
- FETCH: assert `jt_rd_en`=`ecc_rd_en`=1 with both addresses = `cur`. Go to CAPTURE.
- CAPTURE: register `jt_dout[10:0]`→`next`, `jt_dout[15]`→`page_last`, `ecc_dout`→`page_ecc`, and `cur`→`page_addr`. Go to PRESENT.
- PRESENT: `page_valid`=1. Stay until `page_ready`=1. On handshake, increment the counter and go to RELEASE.
- RELEASE (exactly 1 cycle): `rd_op`=1, `rd_addr`=`page_addr`, `rd_port`=`port`.
  - If `page_last`=1: pulse `done`, update `pages_walked`, go to IDLE.
  - Else if counter == `MAX_PAGES`: pulse `done` and `error`, go to IDLE.
  - Else: `cur`←`next`, and assert the FETCH reads for `next` in this same cycle. Go to CAPTURE.
- `start` while `busy`=1 is ignored.
- `next`==`cur` (self-loop) is not detected specially; the guard terminates it.
- Counter is 11-bit. `MAX_PAGES` ≤ 2047.

## Timing
- Reset values: all outputs 0, FSM IDLE.
- `rst` during any state: next cycle IDLE, all outputs 0. No `rd_op` or `done` is emitted for an aborted walk.
- `start` at cycle T: FETCH at T+1, CAPTURE at T+2, `page_valid` first high at T+3.
- Handshake at cycle H: RELEASE with `rd_op` at H+1. Next page's `page_valid` at H+3.
- With `page_ready` tied high, the steady state is 1 page per 3 cycles.
- `busy`=1 from T+1 through the final RELEASE cycle. A new `start` is accepted the cycle after `done`.
- `page_valid` never drops without a handshake. `page_addr`, `page_ecc` and `page_last` do not change while `page_valid`=1.
- `rd_op` is never asserted outside RELEASE. It is exactly 1 cycle per consumed page.

## Test plan
- Single-page walk: jt[5]={last=1,next=0}, ecc[5]=0xA5; `start` at T with addr 5, port 3, ready high. Expect `page_valid` at T+3 with addr 5, ecc 0xA5, last 1. Expect `rd_op` at T+4 with addr 5, port 3. Expect `done` at T+4 and `pages_walked`=1.
- Three-page chain 10→200→2047(last), ready held high. Expect `page_addr` sequence 10, 200, 2047 at T+3, T+6, T+9. Expect 3 `rd_op` pulses and `done` at T+10.
- Backpressure: hold `page_ready` low for 7 cycles on page 2. Page 2's fields stay stable. No `rd_op` until 1 cycle after ready rises. Order and count are unchanged.
- Guard: a chain with no last flag and `MAX_PAGES`=4. Expect exactly 4 `rd_op` pulses, then `done`=`error`=1 together, `pages_walked`=4, and `busy` low next cycle.
- Reset mid-walk: assert `rst` while in PRESENT of page 2. Expect all outputs 0 next cycle and no further `rd_op`. A new `start` is then accepted normally.
- `start` while busy: pulse `start` with addr 99 during a walk. It is ignored, and the current walk completes unchanged.
